// File: rtl/pulse_train_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen_if
// Brief    : Burst request and pulse-output bundle for pulse_train_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_train_gen_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             busy;
  logic             done;
  logic             expect_y;

  modport master (output start, count, gap, input x, busy, done, expect_y);
  modport slave  (input start, count, gap, output x, busy, done, expect_y);
endinterface
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Brief    : Burst pulse generator with shadow copy of the detector phase FSM.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  pulse_train_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] c_gap_one = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  state_t           r_state,     w_state_nxt;
  phase_t           r_phase,     w_phase_nxt;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic [GAP_W-1:0] r_gap_q,     w_gap_q_nxt;
  logic [GAP_W-1:0] r_gap_cnt,   w_gap_cnt_nxt;
  logic             w_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_phase     <= P0;
      r_remaining <= '0;
      r_gap_q     <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_remaining <= w_remaining_nxt;
      r_gap_q     <= w_gap_q_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_gap_q_nxt     = r_gap_q;
    w_gap_cnt_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            w_remaining_nxt = bus.count;
            w_gap_q_nxt     = bus.gap;
            w_state_nxt     = S_PULSE;
          end else begin
            w_state_nxt = S_FIN;
          end
        end
      end
      S_PULSE: begin
        // The last pulse leaves remaining at 1; it is never taken to zero.
        if (r_remaining == c_cnt_one) begin
          w_state_nxt = S_FIN;
        end else begin
          w_remaining_nxt = r_remaining - c_cnt_one;
          if (r_gap_q != '0) begin
            w_gap_cnt_nxt = r_gap_q;
            w_state_nxt   = S_GAP;
          end
        end
      end
      S_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt - c_gap_one;
        if (r_gap_cnt == c_gap_one) w_state_nxt = S_PULSE;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_x = (r_state == S_PULSE);

  // Mirror of the downstream detector: it answers the third pulse of each run.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      P0:      w_phase_nxt = w_x ? P1 : P0;
      P1:      w_phase_nxt = w_x ? P2 : P1;
      P2:      w_phase_nxt = w_x ? P3 : P2;
      P3:      w_phase_nxt = w_x ? P1 : P0;
      default: w_phase_nxt = P0;
    endcase
  end

  assign bus.x        = w_x;
  assign bus.busy     = (r_state == S_PULSE) || (r_state == S_GAP);
  assign bus.done     = (r_state == S_FIN);
  assign bus.expect_y = w_x && (r_phase == P2);

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Brief    : Directed self-checking bench for pulse_train_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pulse_train_gen_if #(.CNT_W(8), .GAP_W(4)) bus ();

  pulse_train_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic xe, input logic be,
                          input logic de, input logic ye);
    chk({tag, ".x"},        bus.x,        xe);
    chk({tag, ".busy"},     bus.busy,     be);
    chk({tag, ".done"},     bus.done,     de);
    chk({tag, ".expect_y"}, bus.expect_y, ye);
  endtask

  // Masks: bit c is the expected value in cycle c (start cycle is 0).
  // smask: bit c pulses start during cycle c to probe that it is ignored.
  task automatic burst(input string tag, input logic [7:0] cnt, input logic [3:0] gp,
                       input int ncyc, input logic [31:0] xm, input logic [31:0] ym,
                       input logic [31:0] bm, input logic [31:0] dm,
                       input logic [31:0] smask);
    bus.start = 1'b1;
    bus.count = cnt;
    bus.gap   = gp;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.start = smask[c];
      bus.count = 8'($urandom_range(0, 255));
      bus.gap   = 4'($urandom_range(0, 15));
      chk_outs($sformatf("%s.c%0d", tag, c), xm[c], bm[c], dm[c], ym[c]);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held with start asserted: nothing may move.
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.count = 8'd3;
    bus.gap   = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_outs($sformatf("rst_hold.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst       = 1'b1;
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_outs($sformatf("idle.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // count=3 gap=0 from P0: y on the third pulse.
    burst("c3g0", 8'd3, 4'd0, 5, 32'h0000_000E, 32'h0000_0008,
          32'h0000_000E, 32'h0000_0010, 32'h0);
    // count=4 gap=2: phase falls back to P0 in the gap after pulse 3; ends in P1.
    burst("c4g2", 8'd4, 4'd2, 12, 32'h0000_0492, 32'h0000_0080,
          32'h0000_07FE, 32'h0000_0800, 32'h0);
    // count=0: done only, phase stays P1.
    burst("c0", 8'd0, 4'd5, 3, 32'h0, 32'h0, 32'h0, 32'h0000_0002, 32'h0);
    // Single pulses walk the persisted phase P1 -> P2, then P2 fires y -> P3 -> P0.
    burst("c1_p1", 8'd1, 4'd3, 3, 32'h0000_0002, 32'h0,
          32'h0000_0002, 32'h0000_0004, 32'h0);
    burst("c1_p2", 8'd1, 4'd0, 3, 32'h0000_0002, 32'h0000_0002,
          32'h0000_0002, 32'h0000_0004, 32'h0);
    // count=6 gap=0 from P0: y on pulses 3 and 6.
    burst("c6g0", 8'd6, 4'd0, 8, 32'h0000_007E, 32'h0000_0048,
          32'h0000_007E, 32'h0000_0080, 32'h0);
    // count=5 gap=1 with start pulsed mid-burst and during done: both ignored.
    burst("c5g1", 8'd5, 4'd1, 12, 32'h0000_02AA, 32'h0000_0020,
          32'h0000_03FE, 32'h0000_0400, 32'h0000_0404);

    // New burst from P2, aborted by reset in cycle 4.
    burst("abort", 8'd5, 4'd1, 4, 32'h0000_000A, 32'h0000_0002,
          32'h0000_001E, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk_outs("abort.async", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_outs($sformatf("abort.hold.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_outs($sformatf("abort.nodone.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Restart after reset: phase back at P0, so y again on pulse 3.
    burst("restart", 8'd3, 4'd0, 5, 32'h0000_000E, 32'h0000_0008,
          32'h0000_000E, 32'h0000_0010, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
